// File: rtl/aes_host_driver.sv
// aes_host_driver: bus master that writes one AES job into the IO register map, starts it and reads the result back.
module aes_host_driver #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int FULL_RETRY  = 64
) (
    input  logic         CLK,
    input  logic         RSTB,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_text,
    input  logic [255:0] req_key,
    input  logic [2:0]   req_nk,
    input  logic         req_op,
    input  logic         req_key_load,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         busy,
    output logic [6:0]   ADDR,
    output logic [7:0]   DIN,
    output logic         WR,
    output logic         START,
    input  logic [7:0]   DOUT,
    input  logic         OK
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int PW = $clog2(FULL_RETRY + 1);
    typedef enum logic [3:0] {IDLE, CFG, KEY, TXT, POLL, GO, WAIT, RD, RESP} state_t;
    state_t state, state_n;
    logic [5:0] idx, idx_n, key_last;
    logic [3:0] rd_byte;
    logic [TW-1:0] tmo, tmo_n;
    logic [PW-1:0] polls, polls_n;
    logic [127:0] text;
    logic [255:0] key;
    logic [2:0] nk;
    logic key_load, nk_ok, err_n, wr_n, start_n;
    logic [6:0] addr_n;
    logic [7:0] din_n;
    assign req_ready = state == IDLE;
    assign busy = state != IDLE;
    assign rsp_valid = state == RESP;
    assign nk_ok = req_nk == 3'd3 || req_nk == 3'd5 || req_nk == 3'd7;
    assign key_last = nk == 3'd3 ? 6'd15 : nk == 3'd5 ? 6'd23 : 6'd31;
    // Byte k arrives two cycles after its address; modulo-16 maps RD index 2..17 onto 0..15.
    assign rd_byte = idx[3:0] - 4'd2;
    always_comb begin
        state_n = state;
        idx_n = idx + 6'd1;
        tmo_n = tmo;
        polls_n = polls;
        err_n = rsp_err;
        case (state)
            IDLE: begin
                idx_n = '0;
                if (req_valid) begin
                    state_n = nk_ok ? CFG : RESP;
                    err_n = !nk_ok;
                end
            end
            CFG: if (idx[0]) begin
                state_n = key_load ? KEY : TXT;
                idx_n = '0;
            end
            KEY: if (idx == key_last) begin
                state_n = TXT;
                idx_n = '0;
            end
            TXT: if (idx == 6'd15) begin
                state_n = POLL;
                idx_n = '0;
                polls_n = '0;
            end
            POLL: if (idx == 6'd2) begin
                idx_n = '0;
                if (!DOUT[0]) state_n = GO;
                else if (polls == PW'(FULL_RETRY - 1)) begin
                    state_n = RESP;
                    err_n = 1'b1;
                end else polls_n = polls + 1'b1;
            end
            GO: begin
                state_n = WAIT;
                tmo_n = '0;
            end
            WAIT: begin
                tmo_n = tmo == TW'(TIMEOUT_CYC) ? tmo : tmo + 1'b1;
                // A stale OK from the previous job is only cleared by START, so skip two cycles.
                if (tmo >= TW'(2) && OK) begin
                    state_n = RD;
                    idx_n = '0;
                end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                    state_n = RESP;
                    err_n = 1'b1;
                end
            end
            RD: if (idx == 6'd17) state_n = RESP;
            RESP: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        wr_n = state_n inside {CFG, KEY, TXT};
        start_n = state_n == GO;
        addr_n = ADDR;
        din_n = DIN;
        case (state_n)
            CFG: begin
                addr_n = {6'b100000, idx_n[0]};
                din_n = idx_n[0] ? {5'b0, nk} : {7'b0, req_op};
            end
            KEY: begin
                addr_n = 7'h20 + {1'b0, idx_n};
                din_n = key[{idx_n[4:0], 3'b0} +: 8];
            end
            TXT: begin
                addr_n = {3'b0, idx_n[3:0]};
                din_n = text[{idx_n[3:0], 3'b0} +: 8];
            end
            POLL: addr_n = 7'h42;
            RD: if (idx_n < 6'd16) addr_n = {3'b001, idx_n[3:0]};
            default: ;
        endcase
    end
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state <= IDLE;
            idx <= '0;
            tmo <= '0;
            polls <= '0;
            text <= '0;
            key <= '0;
            nk <= '0;
            key_load <= 1'b0;
            rsp_err <= 1'b0;
            rsp_data <= '0;
            ADDR <= '0;
            DIN <= '0;
            WR <= 1'b0;
            START <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            tmo <= tmo_n;
            polls <= polls_n;
            rsp_err <= err_n;
            ADDR <= addr_n;
            DIN <= din_n;
            WR <= wr_n;
            START <= start_n;
            if (state == IDLE && req_valid) begin
                text <= req_text;
                key <= req_key;
                nk <= req_nk;
                key_load <= req_key_load;
                if (!nk_ok) rsp_data <= '0;
            end
            if (state == RD && idx >= 6'd2) rsp_data[{rd_byte, 3'b0} +: 8] <= DOUT;
        end
    end
endmodule

// File: tb/tb_aes_host_driver.sv
// tb_aes_host_driver: directed bench with a small IO register-map model (2-cycle read latency).
module tb_aes_host_driver;
    logic CLK = 0, RSTB = 0, req_valid = 0, req_op = 0, req_key_load = 0, rsp_ready = 0, OK = 0;
    logic [127:0] req_text = '0;
    logic [255:0] req_key = '0;
    logic [2:0] req_nk = '0;
    logic req_ready, rsp_valid, rsp_err, busy, WR, START;
    logic [127:0] rsp_data;
    logic [6:0] ADDR;
    logic [7:0] DIN;
    logic [7:0] DOUT = '0, r1 = '0;
    logic [7:0] mem [128];
    logic full = 0;
    logic [3:0] res_hi = 4'hC;
    int cyc = 0, wr_cnt = 0, key_wr = 0, start_cnt = 0;
    int errors = 0, checks = 0;
    logic [127:0] t1 = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] t2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    logic [255:0] k1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    logic [255:0] k2 = 256'hf0e1d2c3b4a5968778695a4b3c2d1e0f8899aabbccddeeff0123456789abcdef;

    aes_host_driver dut (
        .CLK(CLK), .RSTB(RSTB), .req_valid(req_valid), .req_ready(req_ready),
        .req_text(req_text), .req_key(req_key), .req_nk(req_nk), .req_op(req_op),
        .req_key_load(req_key_load), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .ADDR(ADDR), .DIN(DIN),
        .WR(WR), .START(START), .DOUT(DOUT), .OK(OK)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (WR) mem[ADDR] <= DIN;
        r1 <= ADDR == 7'h42 ? {7'b0, full} : ADDR[6:4] == 3'b001 ? {res_hi, ADDR[3:0]} : mem[ADDR];
        DOUT <= r1;
        if (WR) wr_cnt <= wr_cnt + 1;
        if (WR && ADDR[6:5] == 2'b01) key_wr <= key_wr + 1;
        if (START) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] exp_data(input logic [3:0] hi);
        logic [127:0] d;
        for (int k = 0; k < 16; k++) d[8*k +: 8] = {hi, 4'(k)};
        return d;
    endfunction

    task automatic chk_mem(input string tag, input int base, input int n, input logic [255:0] v);
        logic bad = 0;
        for (int k = 0; k < n; k++) if (mem[base + k] !== v[8*k +: 8]) bad = 1;
        chk(tag, bad, 0);
    endtask

    task automatic issue(input logic [127:0] t, input logic [255:0] k, input logic [2:0] nk,
                         input logic op, input logic kl);
        chk("req_ready_idle", req_ready, 1);
        req_text = t; req_key = k; req_nk = nk; req_op = op; req_key_load = kl; req_valid = 1;
        tick();
        req_valid = 0; req_text = ~t; req_key = ~k; req_op = ~op; req_key_load = ~kl;
    endtask

    task automatic wait_start(output int s);
        int n = 0;
        while (!START && n < 600) begin tick(); n++; end
        chk("start_seen", START, 1);
        s = cyc;
    endtask

    task automatic wait_rsp(input int lim, output int r);
        int n = 0;
        while (!rsp_valid && n < lim) begin tick(); n++; end
        chk("rsp_seen", rsp_valid, 1);
        r = cyc;
    endtask

    task automatic wait_txt_end(output int t);
        int n = 0;
        while (!(WR && ADDR == 7'h0F) && n < 200) begin tick(); n++; end
        chk("txt_end_seen", WR && ADDR == 7'h0F, 1);
        t = cyc;
    endtask

    task automatic ack();
        OK = 0;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("rsp_drop", rsp_valid, 0);
        chk("back_idle", {req_ready, busy}, 2'b10);
    endtask

    initial begin
        int s, r, t, w0, k0, s0, n;
        repeat (3) tick();
        chk("rst_outputs", {ADDR, DIN, WR, START, rsp_valid, rsp_err, busy, rsp_data}, 0);
        chk("rst_req_ready", req_ready, 1);
        RSTB = 1;
        tick();

        w0 = wr_cnt; k0 = key_wr;
        issue(t1, k1, 3'd3, 1, 1);
        wait_start(s);
        repeat (100) tick();
        OK = 1;
        wait_rsp(400, r);
        chk("t1_latency", r - s, 119);
        chk("t1_data", rsp_data, exp_data(4'hC));
        chk("t1_err", rsp_err, 0);
        chk("t1_wr_count", wr_cnt - w0, 34);
        chk("t1_key_writes", key_wr - k0, 16);
        chk("t1_cfg", {mem[64], mem[65]}, 16'h0103);
        chk_mem("t1_text_bytes", 0, 16, {128'b0, t1});
        chk_mem("t1_key_bytes", 32, 16, k1);
        ack();

        res_hi = 4'h5;
        w0 = wr_cnt; k0 = key_wr;
        issue(t2, k2, 3'd7, 0, 1);
        wait_start(s);
        repeat (10) tick();
        OK = 1;
        wait_rsp(400, r);
        chk("t2a_data", rsp_data, exp_data(4'h5));
        chk("t2a_wr_count", wr_cnt - w0, 50);
        chk("t2a_key_writes", key_wr - k0, 32);
        chk("t2a_cfg", {mem[64], mem[65]}, 16'h0007);
        chk_mem("t2a_key_bytes", 32, 32, k2);
        chk_mem("t2a_text_bytes", 0, 16, {128'b0, t2});
        ack();
        res_hi = 4'hA;
        w0 = wr_cnt; k0 = key_wr;
        issue(t1, k1, 3'd7, 1, 0);
        wait_start(s);
        repeat (10) tick();
        OK = 1;
        wait_rsp(400, r);
        chk("t2b_data", rsp_data, exp_data(4'hA));
        chk("t2b_wr_count", wr_cnt - w0, 18);
        chk("t2b_key_writes", key_wr - k0, 0);
        chk_mem("t2b_key_kept", 32, 32, k2);
        ack();

        res_hi = 4'h3;
        full = 1;
        s0 = start_cnt;
        issue(t1, k1, 3'd3, 1, 1);
        wait_txt_end(t);
        repeat (10) tick();
        full = 0;
        wait_start(s);
        chk("t4a_start_after_poll4", s - t, 13);
        OK = 1;
        wait_rsp(400, r);
        chk("t4a_stale_window_latency", r - s, 22);
        chk("t4a_data", rsp_data, exp_data(4'h3));
        chk("t4a_start_count", start_cnt - s0, 1);
        ack();
        full = 1;
        s0 = start_cnt;
        issue(t1, k1, 3'd3, 1, 1);
        wait_txt_end(t);
        wait_rsp(400, r);
        chk("t4b_retry_latency", r - t, 193);
        chk("t4b_err", rsp_err, 1);
        chk("t4b_no_start", start_cnt - s0, 0);
        full = 0;
        ack();

        res_hi = 4'h9;
        OK = 1;
        issue(t2, k2, 3'd5, 0, 1);
        wait_start(s);
        tick();
        tick();
        OK = 0;
        repeat (49) tick();
        OK = 1;
        wait_rsp(400, r);
        chk("t5a_latency", r - s, 70);
        chk("t5a_data", rsp_data, exp_data(4'h9));
        chk("t5a_err", rsp_err, 0);
        ack();
        res_hi = 4'h1;
        issue(t2, k2, 3'd5, 0, 1);
        wait_start(s);
        wait_rsp(5000, r);
        chk("t5b_timeout_latency", r - s, 4097);
        chk("t5b_err", rsp_err, 1);
        chk("t5b_data_held", rsp_data, exp_data(4'h9));
        ack();

        w0 = wr_cnt; s0 = start_cnt;
        issue(t1, k1, 3'd4, 1, 1);
        chk("t3_rsp_next_cycle", {rsp_valid, rsp_err}, 2'b11);
        chk("t3_data_zero", rsp_data, 0);
        repeat (3) tick();
        chk("t3_still_valid", rsp_valid, 1);
        chk("t3_no_bus", {wr_cnt - w0, start_cnt - s0}, 0);
        ack();

        res_hi = 4'hE;
        issue(t1, k1, 3'd3, 1, 1);
        n = 0;
        while (!(WR && ADDR == 7'h05) && n < 200) begin tick(); n++; end
        chk("t6_mid_txt_seen", WR && ADDR == 7'h05, 1);
        RSTB = 0;
        #1;
        chk("t6_async_rst", {ADDR, DIN, WR, START, rsp_valid, rsp_err, busy, rsp_data}, 0);
        chk("t6_rst_req_ready", req_ready, 1);
        tick();
        RSTB = 1;
        tick();
        issue(t2, k1, 3'd3, 1, 1);
        wait_start(s);
        repeat (10) tick();
        OK = 1;
        wait_rsp(400, r);
        chk("t6_latency", r - s, 29);
        chk("t6_data", rsp_data, exp_data(4'hE));
        chk_mem("t6_text_bytes", 0, 16, {128'b0, t2});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_hold", {rsp_valid, req_ready, rsp_data}, {2'b10, exp_data(4'hE)});
        end
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
